// File: rtl/siren_tone_decoder_pkg.sv
// Shared types and constants for the siren tone decoder.
package siren_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_e;

  // Siren sweep range, in osc_CLK cycles
  localparam int unsigned SIREN_PERIOD_MIN = 32770;
  localparam int unsigned SIREN_PERIOD_MAX = 65282;
  localparam int unsigned SIREN_PERIOD_W   = 17;

endpackage

// File: rtl/siren_tone_decoder_if.sv
// Tone pin and measurement outputs of the siren tone decoder.
interface siren_tone_decoder_if
  import siren_pkg::*;
#(
  parameter int unsigned PERIOD_W = SIREN_PERIOD_W
) ();

  logic                pin_in;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                tone_present;
  logic                sweep_up;
  logic                sweep_down;

  modport master (
    output pin_in,
    input  period, period_valid, tone_present, sweep_up, sweep_down
  );

  modport slave (
    input  pin_in,
    output period, period_valid, tone_present, sweep_up, sweep_down
  );

endinterface

// File: rtl/siren_tone_decoder_sync_edge_det.sv
// Input synchronizer for an asynchronous pin plus a rising-edge pulse.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/siren_tone_decoder.sv
// Measures rising-edge-to-rising-edge period of a tone on an asynchronous pin.
// Optional sweep-direction outputs are built when SIREN_SWEEP_EN is defined.
module siren_tone_decoder
  import siren_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PERIOD_W    = SIREN_PERIOD_W,
  parameter int unsigned MIN_PERIOD  = 1024,
  parameter int unsigned MAX_PERIOD  = 131071,
  parameter int unsigned SWEEP_HYST  = 64
) (
  input logic                 osc_CLK,
  input logic                 rst,
  siren_tone_decoder_if.slave bus
);

  localparam logic [PERIOD_W-1:0] MIN_CNT = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_CNT = PERIOD_W'(MAX_PERIOD);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (64'(MAX_PERIOD) > ((64'd1 << PERIOD_W) - 64'd1)) begin : g_bad_max
    $error("MAX_PERIOD does not fit in PERIOD_W bits");
  end
  if (SWEEP_HYST > MAX_PERIOD) begin : g_bad_hyst
    $error("SWEEP_HYST larger than MAX_PERIOD");
  end

  logic rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk   (osc_CLK),
    .rst   (rst),
    .pin_in(bus.pin_in),
    .rise  (rise)
  );

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                tone_present_q, tone_present_d;
  logic                accept;
  logic                timeout;

  // Accept beats timeout when both land on the same cycle
  assign accept  = rise && (state_q != IDLE) && (cnt_q >= MIN_CNT);
  assign timeout = !accept && (state_q != IDLE) && (cnt_q == MAX_CNT);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    tone_present_d = tone_present_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ARMED;
          cnt_d   = PERIOD_W'(1);
        end
      end
      ARMED, MEASURE: begin
        if (accept) begin
          state_d        = MEASURE;
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          tone_present_d = 1'b1;
          cnt_d          = PERIOD_W'(1);
        end else if (timeout) begin
          state_d        = IDLE;
          tone_present_d = 1'b0;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge osc_CLK) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      tone_present_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      tone_present_q <= tone_present_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.tone_present = tone_present_q;

`ifdef SIREN_SWEEP_EN
  localparam logic [PERIOD_W:0] HYST = (PERIOD_W + 1)'(SWEEP_HYST);

  logic [PERIOD_W-1:0] last_period_q, last_period_d;
  logic                sweep_up_q, sweep_up_d;
  logic                sweep_down_q, sweep_down_d;
  logic [PERIOD_W:0]   new_ext, last_ext;

  assign new_ext  = {1'b0, cnt_q};
  assign last_ext = {1'b0, last_period_q};

  // Direction only compares once a previous period exists (second accept onward)
  always_comb begin
    last_period_d = last_period_q;
    sweep_up_d    = sweep_up_q;
    sweep_down_d  = sweep_down_q;
    if (accept) begin
      last_period_d = cnt_q;
      if (state_q == MEASURE) begin
        if (new_ext > last_ext + HYST) begin
          sweep_down_d = 1'b1;
          sweep_up_d   = 1'b0;
        end else if (new_ext + HYST < last_ext) begin
          sweep_up_d   = 1'b1;
          sweep_down_d = 1'b0;
        end
      end
    end else if (timeout) begin
      sweep_up_d   = 1'b0;
      sweep_down_d = 1'b0;
    end
  end

  always_ff @(posedge osc_CLK) begin
    if (rst) begin
      last_period_q <= '0;
      sweep_up_q    <= 1'b0;
      sweep_down_q  <= 1'b0;
    end else begin
      last_period_q <= last_period_d;
      sweep_up_q    <= sweep_up_d;
      sweep_down_q  <= sweep_down_d;
    end
  end

  assign bus.sweep_up   = sweep_up_q;
  assign bus.sweep_down = sweep_down_q;
`else
  assign bus.sweep_up   = 1'b0;
  assign bus.sweep_down = 1'b0;
`endif

endmodule
